// File: rtl/alu_operand_sequencer_if.sv
// ALU operand/result bus between the operand sequencer (master) and the
// combinational one-hot ALU (slave).
interface alu_operand_sequencer_if;
  logic [15:0] inp1;
  logic [15:0] inp2;
  logic [2:0]  opc;
  logic [15:0] alu_out;
  logic        alu_ovf;
  logic [6:0]  alu_seg;

  modport master (
    output inp1, inp2, opc,
    input  alu_out, alu_ovf, alu_seg
  );

  modport slave (
    input  inp1, inp2, opc,
    output alu_out, alu_ovf, alu_seg
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Keypad front end for the one-hot ALU: debounces operand A and B key
// presses, commits an opcode on enter, then captures the ALU result for display.
module alu_operand_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [15:0]                    key_onehot,
  input  logic [2:0]                     op_key,
  input  logic                           enter,
  input  logic                           clear,
  alu_operand_sequencer_if.master        alu,
  output logic [15:0]                    result,
  output logic                           result_ovf,
  output logic [6:0]                     seg_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] TMO_C  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SHOW
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      key_prev_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             armed_q, armed_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      inp1_q, inp1_d;
  logic [15:0]      inp2_q, inp2_d;
  logic [2:0]       opc_q, opc_d;
  logic [15:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       seg_q, seg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic key_same, hold_hit, accept, bad_key, waiting, timeout;

  // Key stability counter: saturates at HOLD_CYCLES so a held key only
  // produces a single hold_hit, on the cycle the count first completes.
  always_comb begin
    key_same   = (key_onehot == key_prev_q);
    stab_cnt_d = CNT_W'(1);
    if (key_same) begin
      if (stab_cnt_q == HOLD_C) stab_cnt_d = stab_cnt_q;
      else                      stab_cnt_d = stab_cnt_q + 1'b1;
    end
    hold_hit = (stab_cnt_d == HOLD_C) && !(key_same && (stab_cnt_q == HOLD_C));
    accept   = hold_hit && $onehot(key_onehot) && armed_q;
    bad_key  = hold_hit && (key_onehot != '0) && !$onehot(key_onehot);
    armed_d  = armed_q;
    if (key_onehot == '0) armed_d = 1'b1;
    else if (accept)      armed_d = 1'b0;
  end

  // Next-state and datapath update; clear overrides every transition.
  always_comb begin
    state_d  = state_q;
    inp1_d   = inp1_q;
    inp2_d   = inp2_q;
    opc_d    = opc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    seg_d    = seg_q;
    done_d   = 1'b0;
    err_d    = err_q | bad_key;
    waiting  = (state_q == S_GET_B) || (state_q == S_GET_OP);
    timeout  = waiting && !accept && (tmr_q == TMO_C);

    if (clear) begin
      state_d = S_IDLE;
      inp1_d  = '0;
      inp2_d  = '0;
      opc_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_SHOW: begin
          if (accept) begin
            inp1_d  = key_onehot;
            inp2_d  = '0;
            opc_d   = '0;
            state_d = S_GET_B;
          end
        end
        S_GET_B: begin
          if (accept) begin
            inp2_d  = key_onehot;
            state_d = S_GET_OP;
          end
        end
        S_GET_OP: begin
          // enter beats a simultaneous key accept; the key is simply dropped
          if (enter && (op_key != '0)) begin
            opc_d   = op_key;
            state_d = S_EXEC;
          end else if (enter) begin
            err_d = 1'b1;
          end
        end
        S_EXEC: begin
          result_d = alu.alu_out;
          ovf_d    = alu.alu_ovf;
          seg_d    = alu.alu_seg;
          done_d   = 1'b1;
          state_d  = S_SHOW;
        end
        default: state_d = S_IDLE;
      endcase

      if (timeout && (state_d == state_q)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        inp1_d  = '0;
        inp2_d  = '0;
        opc_d   = '0;
      end
    end

    tmr_d = '0;
    if ((state_d == state_q) && !accept && waiting) tmr_d = tmr_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_prev_q <= '0;
      stab_cnt_q <= '0;
      armed_q    <= 1'b1;
      tmr_q      <= '0;
      inp1_q     <= '0;
      inp2_q     <= '0;
      opc_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      seg_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_onehot;
      stab_cnt_q <= stab_cnt_d;
      armed_q    <= armed_d;
      tmr_q      <= tmr_d;
      inp1_q     <= inp1_d;
      inp2_q     <= inp2_d;
      opc_q      <= opc_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign alu.inp1   = inp1_q;
  assign alu.inp2   = inp2_q;
  assign alu.opc    = opc_q;
  assign result     = result_q;
  assign result_ovf = ovf_q;
  assign seg_out    = seg_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q == S_GET_B) || (state_q == S_GET_OP) || (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a behavioural one-hot ALU as responder
// and a history-based reference model compared on every falling edge.
module tb_alu_operand_sequencer;
  localparam int HOLD = 4;
  localparam int TMO  = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_onehot;
  logic [2:0]  op_key;
  logic        enter, clear;
  logic [15:0] result;
  logic        result_ovf, busy, done, err;
  logic [6:0]  seg_out;

  int tests = 0;
  int fails = 0;

  alu_operand_sequencer_if alu_if ();

  alu_operand_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_onehot (key_onehot),
    .op_key     (op_key),
    .enter      (enter),
    .clear      (clear),
    .alu        (alu_if.master),
    .result     (result),
    .result_ovf (result_ovf),
    .seg_out    (seg_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Returns {ovf, seg[6:0], out[15:0]}
  function automatic logic [23:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    int ia = idx(a);
    int ib = idx(b);
    int r  = 0;
    logic ov = 1'b0;
    case (op)
      3'd1: begin r = ia + ib; ov = (r > 15); end
      3'd2: begin r = ia - ib; ov = (ia < ib); end
      3'd3: begin r = ia * ib; ov = (r > 15); end
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      3'd7: r = (ia > ib) ? ia : ib;
      default: r = 0;
    endcase
    r = r & 15;
    return {ov, seg7(r), 16'(16'd1 << r)};
  endfunction

  always_comb {alu_if.alu_ovf, alu_if.alu_seg, alu_if.alu_out} =
      alu_fn(alu_if.inp1, alu_if.inp2, alu_if.opc);

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for B, 2 waiting for opcode, 3 exec, 4 showing
  int          m_phase, m_idle;
  logic [15:0] hist [0:HOLD];
  logic        m_used;
  logic [15:0] m_inp1, m_inp2, m_res;
  logic [2:0]  m_opc;
  logic        m_ovf, m_done, m_err;
  logic [6:0]  m_seg;

  task automatic model_reset();
    for (int i = 0; i <= HOLD; i++) hist[i] = '0;
    m_phase = 0; m_idle = 0; m_used = 1'b0;
    m_inp1 = '0; m_inp2 = '0; m_opc = '0;
    m_res = '0; m_ovf = 1'b0; m_seg = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    logic stable, acc, bad, tmo;
    int   prev;
    for (int i = HOLD; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = key_onehot;
    // accepted when the last HOLD samples agree and the one before them differs
    stable = (hist[HOLD] != key_onehot);
    for (int i = 0; i < HOLD; i++) if (hist[i] != key_onehot) stable = 1'b0;
    acc = stable && ($countones(key_onehot) == 1) && !m_used;
    bad = stable && ($countones(key_onehot) > 1);
    if (key_onehot == '0) m_used = 1'b0;
    else if (acc)         m_used = 1'b1;

    prev   = m_phase;
    m_done = 1'b0;
    tmo    = (m_phase == 1 || m_phase == 2) && !acc && (m_idle + 1 == TMO);
    if (clear) begin
      m_phase = 0; m_inp1 = '0; m_inp2 = '0; m_opc = '0; m_err = 1'b0;
    end else begin
      if (bad) m_err = 1'b1;
      if ((m_phase == 0 || m_phase == 4) && acc) begin
        m_inp1 = key_onehot; m_inp2 = '0; m_opc = '0; m_phase = 1;
      end else if (m_phase == 1 && acc) begin
        m_inp2 = key_onehot; m_phase = 2;
      end else if (m_phase == 2 && enter && op_key != 3'd0) begin
        m_opc = op_key; m_phase = 3;
      end else if (m_phase == 3) begin
        {m_ovf, m_seg, m_res} = alu_fn(m_inp1, m_inp2, m_opc);
        m_done = 1'b1; m_phase = 4;
      end else begin
        if (m_phase == 2 && enter) m_err = 1'b1;
        if (tmo) begin
          m_err = 1'b1; m_phase = 0; m_inp1 = '0; m_inp2 = '0; m_opc = '0;
        end
      end
    end
    if (m_phase != prev || acc || !(m_phase == 1 || m_phase == 2)) m_idle = 0;
    else m_idle = m_idle + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("inp1",   alu_if.inp1,  m_inp1);
    chk("inp2",   alu_if.inp2,  m_inp2);
    chk("opc",    16'(alu_if.opc), 16'(m_opc));
    chk("result", result, m_res);
    chk("ovf",    16'(result_ovf), 16'(m_ovf));
    chk("seg",    16'(seg_out), 16'(m_seg));
    chk("busy",   16'(busy), 16'(m_phase >= 1 && m_phase <= 3));
    chk("done",   16'(done), 16'(m_done));
    chk("err",    16'(err), 16'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [15:0] k, input int n);
    key_onehot = k;
    repeat (n) @(negedge clk);
    key_onehot = '0;
    @(negedge clk);
  endtask

  task automatic do_op(input logic [2:0] op);
    op_key = op;
    enter  = 1'b1;
    @(negedge clk);
    enter  = 1'b0;
    op_key = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run_calc(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic [15:0] exp_res, input logic exp_ovf,
                          input logic [6:0] exp_seg, input string tag);
    press(a, HOLD);
    press(b, HOLD);
    do_op(op);
    chk({tag, "_exec_busy"}, 16'(busy), 16'd1);
    chk({tag, "_exec_nodone"}, 16'(done), 16'd0);
    @(negedge clk);
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_ovf"}, 16'(result_ovf), 16'(exp_ovf));
    chk({tag, "_seg"}, 16'(seg_out), 16'(exp_seg));
    chk({tag, "_seg_alu"}, 16'(seg_out), 16'(alu_if.alu_seg));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 16'(done), 16'd0);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; key_onehot = '0; op_key = '0; enter = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 16'h0000);
    chk("reset_err", 16'(err), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 3 = 8
    run_calc(16'h0020, 16'h0008, 3'd1, 16'h0100, 1'b0, 7'h7F, "t1");
    // 9 + 9 = 18 -> 2 with overflow
    run_calc(16'h0200, 16'h0200, 3'd1, 16'h0004, 1'b1, 7'h5B, "t2");

    // multi-bit key held in IDLE
    pulse_clear();
    key_onehot = 16'h0011;
    repeat (10) @(negedge clk);
    chk("t3_err", 16'(err), 16'd1);
    chk("t3_idle", 16'(busy), 16'd0);
    chk("t3_inp1", alu_if.inp1, 16'h0000);
    key_onehot = '0;
    @(negedge clk);
    pulse_clear();
    chk("t3_clear", 16'(err), 16'd0);

    // short press then full press: exactly one accept, no second while held
    key_onehot = 16'h0004;
    repeat (3) @(negedge clk);
    key_onehot = '0;
    @(negedge clk);
    key_onehot = 16'h0004;
    repeat (8) @(negedge clk);
    chk("t4_inp1", alu_if.inp1, 16'h0004);
    chk("t4_inp2", alu_if.inp2, 16'h0000);
    chk("t4_busy", 16'(busy), 16'd1);
    key_onehot = '0;
    @(negedge clk);

    // timeout in GET_B
    waited = 0;
    while (!err && waited < TMO + 10) begin
      @(negedge clk);
      waited++;
    end
    chk("t5_err", 16'(err), 16'd1);
    chk("t5_idle", 16'(busy), 16'd0);
    chk("t5_inp1", alu_if.inp1, 16'h0000);
    pulse_clear();
    chk("t5_clear", 16'(err), 16'd0);

    // async reset in EXEC
    press(16'h0010, HOLD);
    press(16'h0002, HOLD);
    do_op(3'd3);
    chk("t6_exec", 16'(busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_inp1", alu_if.inp1, 16'h0000);
    chk("t6_rst_opc", 16'(alu_if.opc), 16'd0);
    chk("t6_rst_result", result, 16'h0000);
    chk("t6_rst_seg", 16'(seg_out), 16'd0);
    chk("t6_rst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    chk("t6_nodone", 16'(done), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // 7 - 2 = 5
    run_calc(16'h0080, 16'h0004, 3'd2, 16'h0020, 1'b0, 7'h6D, "t6b");

    // randomized traffic; the per-cycle compare process checks everything
    for (int n = 0; n < 500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_clear();
      end else if (r < 5) begin
        key_onehot = '0;
        repeat (TMO + 3) @(negedge clk);
      end else if (r < 17) begin
        do_op(3'($urandom_range(0, 7)));
      end else begin
        int k = $urandom_range(0, 99);
        if (k < 65)      key_onehot = 16'(16'd1 << $urandom_range(0, 15));
        else if (k < 75) key_onehot = 16'(16'h0101 << $urandom_range(0, 7));
        else             key_onehot = '0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    key_onehot = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
